// File: rtl/aes_ctr_stream.sv
// AES-128 counter-mode keystream XOR engine with valid/ready streaming and a
// credit-managed output FIFO; includes the 21-cycle pipelined aes_128 core.

module aes_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic [127:0] plain,
    output logic [127:0] cipher
);

    logic [127:0] st_r  [0:10];
    logic [127:0] sb_r  [1:10];
    logic [127:0] rka_r [1:10];
    logic [127:0] rk_r  [0:9];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Round pipeline: each round is split into SubBytes and ShiftRows/MixColumns/AddRoundKey
    // stages; the round key travels with the state so the key may change between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= 10; i++) st_r[i] <= 128'h0;
            for (int i = 1; i <= 10; i++) begin
                sb_r[i]  <= 128'h0;
                rka_r[i] <= 128'h0;
            end
            for (int i = 0; i < 10; i++) rk_r[i] <= 128'h0;
        end else begin
            st_r[0] <= plain ^ key;
            rk_r[0] <= key;
            for (int r = 1; r <= 10; r++) begin
                sb_r[r]  <= sub_bytes(st_r[r-1]);
                rka_r[r] <= key_expand(rk_r[r-1], rcon(r[3:0]));
                if (r == 10) begin
                    st_r[r] <= shift_rows(sb_r[r]) ^ rka_r[r];
                end else begin
                    st_r[r] <= mix_columns(shift_rows(sb_r[r])) ^ rka_r[r];
                    rk_r[r] <= rka_r[r];
                end
            end
        end
    end

    assign cipher = st_r[10];

endmodule

module aes_ctr_stream #(
    parameter int AES_LATENCY = 21,
    parameter int CTR_W       = 32,
    parameter int FIFO_DEPTH  = 32,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key,
    input  logic [127-CTR_W:0] nonce,
    input  logic [CTR_W-1:0]   ctr_init,
    input  logic [CNT_W-1:0]   num_blocks,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               busy,
    output logic               done,
    output logic               ctr_wrap
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t               state_r, state_nxt_s;
    logic [127:0]         key_r;
    logic [127-CTR_W:0]   nonce_r;
    logic [CTR_W-1:0]     ctr_r;
    logic [CNT_W-1:0]     remaining_r;
    logic                 ctr_wrap_r, in_ready_r, out_valid_r, busy_r, done_r;
    logic [AES_LATENCY-1:0] vld_r;
    logic [127:0]         dly_r [0:AES_LATENCY-1];
    logic [127:0]         mem_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [OCC_W-1:0]     fifo_cnt_r, fifo_cnt_nxt_s, occ_r, occ_nxt_s;
    logic [127:0]         aes_out_s;
    logic                 accept_s, pop_s, push_s;

    assign accept_s = in_valid && in_ready_r;
    assign pop_s    = out_valid_r && out_ready;
    assign push_s   = vld_r[AES_LATENCY-1];

    aes_128 u_aes (
        .clk    (clk),
        .rst    (rst),
        .key    (key_r),
        .plain  ({nonce_r, ctr_r}),
        .cipher (aes_out_s)
    );

    // Occupancy counts blocks in flight plus FIFO entries; it is the credit pool for in_ready.
    always_comb begin
        occ_nxt_s      = occ_r;
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({accept_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1'b1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1'b1);
            default: occ_nxt_s = occ_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + OCC_W'(1'b1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - OCC_W'(1'b1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Job sequencing; DRAIN exits using next-cycle occupancy so done follows the last pop directly.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = (num_blocks == {CNT_W{1'b0}}) ? DRAIN : RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (accept_s && (remaining_r == CNT_W'(1'b1))) state_nxt_s = DRAIN;
                else                                           state_nxt_s = RUN;
            end
            DRAIN: begin
                if (occ_nxt_s == {OCC_W{1'b0}}) state_nxt_s = IDLE;
                else                            state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control state, job registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            key_r       <= 128'h0;
            nonce_r     <= '0;
            ctr_r       <= {CTR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            ctr_wrap_r  <= 1'b0;
            occ_r       <= {OCC_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            occ_r      <= occ_nxt_s;
            in_ready_r <= (state_nxt_s == RUN) && (occ_nxt_s < DEPTH_V);
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_r == DRAIN) && (state_nxt_s == IDLE);
            if ((state_r == IDLE) && start) begin
                key_r       <= key;
                nonce_r     <= nonce;
                ctr_r       <= ctr_init;
                remaining_r <= num_blocks;
                ctr_wrap_r  <= 1'b0;
            end else if (accept_s) begin
                ctr_r       <= ctr_r + CTR_W'(1'b1);
                remaining_r <= remaining_r - CNT_W'(1'b1);
                if (&ctr_r) ctr_wrap_r <= 1'b1;
            end
        end
    end

    // Data and valid delay lines matched to the AES core latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {AES_LATENCY{1'b0}};
            for (int i = 0; i < AES_LATENCY; i++) dly_r[i] <= 128'h0;
        end else begin
            vld_r    <= {vld_r[AES_LATENCY-2:0], accept_s};
            dly_r[0] <= in_data;
            for (int i = 1; i < AES_LATENCY; i++) dly_r[i] <= dly_r[i-1];
        end
    end

    // Output FIFO; credit accounting guarantees a pipeline exit never finds it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 128'h0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {OCC_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= aes_out_s ^ dly_r[AES_LATENCY-1];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            out_valid_r <= (fifo_cnt_nxt_s != {OCC_W{1'b0}});
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign busy      = busy_r;
    assign done      = done_r;
    assign ctr_wrap  = ctr_wrap_r;

endmodule

// File: doc/aes_ctr_stream.md
Name: aes_ctr_stream

Overview:
- AES-128 counter-mode keystream XOR engine with a valid/ready stream interface.
- For each accepted 128-bit block it encrypts {nonce, counter} through the pipelined aes_128 core, then XORs the keystream with the data.
- It increments the counter per block, runs for a programmed block count, and buffers results in an output FIFO so that output backpressure never stalls the non-stallable AES pipeline.
- It sits between the secure-memory bus adapter and the memory datapath, and is used for both encrypt and decrypt.

Parameters:
- AES_LATENCY, 21, cycles from aes_128 state input to its output; must equal the instantiated core's latency.
- CTR_W, 32, counter width in bits (8..64); the nonce occupies the upper 128-CTR_W bits.
- FIFO_DEPTH, 32, output FIFO entries; power of two, at least AES_LATENCY+1 for full throughput.
- CNT_W, 16, width of the block-count input.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse that loads a job; honoured only in IDLE
- key  in  128  AES key, latched on start
- nonce  in  128-CTR_W  upper bits of the counter block, latched on start
- ctr_init  in  CTR_W  initial counter value, latched on start
- num_blocks  in  CNT_W  number of blocks in the job, latched on start
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid&&in_ready
- in_data  in  128  plaintext or ciphertext block
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink ready
- out_data  out  128  in_data XOR AES(key, {nonce,ctr})
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse on return to IDLE
- ctr_wrap  out  1  sticky; set when the counter wraps within a job, cleared on start

Behaviour:
- Reset: every register clears; all outputs read 0 (in_ready, out_valid, out_data, busy, done, ctr_wrap). The pipeline valid shift register and FIFO pointers are cleared, so in-flight AES results are discarded. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + start: latch key, nonce, ctr_init into ctr, and num_blocks into remaining; clear ctr_wrap. Go to RUN, or to DRAIN if num_blocks==0.
  - start outside IDLE is ignored.
  - RUN: go to DRAIN on the accept that brings remaining to 0.
  - DRAIN: go to IDLE when the in-flight count is 0 and the FIFO is empty. done pulses in the cycle the FSM is in IDLE after the transition.
  - num_blocks==0: done is asserted 2 cycles after start.
- in_ready = (state==RUN) && (occ < FIFO_DEPTH), where occ = in-flight blocks + FIFO entries.
  - occ increments on an accept and decrements on an output pop; both in one cycle leave it unchanged.
  - Because acceptance is credit-based, a pipeline exit always finds FIFO space; overflow is impossible by construction.
- Accept at edge T:
  - The aes_128 state input is {nonce_q, ctr}.
  - in_data enters an AES_LATENCY-stage data delay line; a 1 enters the valid shift register.
  - ctr <= ctr+1 mod 2^CTR_W; if the old ctr was all ones, ctr_wrap <= 1. remaining decrements.
- Pipeline exit at T+AES_LATENCY: the value aes_out XOR delayed data is written to the FIFO. out_valid is first high in cycle T+AES_LATENCY+1 when the FIFO was empty. Back-to-back accepts yield back-to-back outputs; 1 block per cycle is sustained when out_ready is held.
- Output stream:
  - out_valid = FIFO not empty.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop are legal, including when the FIFO is full or empty; a push into an empty FIFO is not bypassed.
  - out_data holds stable while out_valid && !out_ready.
- The key is held constant to the core for the whole job. The aes_128 input is don't-care when there is no accept, because its output is qualified by the valid shift register.
- Output order equals input order; the counter value is bound to the block at its accept.

Test Plan:
- FIPS-197 vector: key=2b7e1516_28aed2a6_abf71588_09cf4f3c, nonce=3243f6a8885a308d313198a2, ctr_init=e0370734, num_blocks=1, in_data=0 -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid at accept+22. done is asserted 1 cycle after that block pops; busy is 0 afterwards.
- Same key and nonce, in_data=3925841d02dc09fbdc118597196a0b32 -> out_data=0, confirming encrypt/decrypt symmetry.
- num_blocks=64, in_valid and out_ready held high, ctr_init=0 -> 64 outputs on consecutive cycles; block i equals a software model using ctr=i; in_ready never drops.
- Backpressure: out_ready=0 with num_blocks=40 -> exactly 32 accepts, then in_ready=0. Raising out_ready drains all 40 blocks in order with no loss or duplication.
- Wrap: CTR_W=32, ctr_init=ffffffff, num_blocks=2 -> the second block uses ctr=00000000 and the upper nonce bits are unchanged. ctr_wrap is 1 after the second accept and clears on the next start.
- Reset while 10 blocks are in flight -> on the next cycle out_valid=0, busy=0, in_ready=0, no done pulse; a subsequent job produces correct outputs with no stale data.
